// File: rtl/bus_pkg.sv
// Shared CPU-bus definitions: transfer mode encoding, SRAM slave FSM states and
// the fill value returned for reads that miss the mapped window.
package bus_pkg;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StWresp,
        StRresp,
        StTurn
    } slave_state_e;

    // Every bit of an out-of-window read word takes this value.
    localparam logic OOB_RDATA_BIT = 1'b1;

endpackage

// File: rtl/sram_1rw.sv
// Single-port word SRAM: synchronous write, registered read, no reset.
// The read register only updates when re is high, so its output holds between reads.
module sram_1rw #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM target for the valid/ready CPU bus with programmable wait states.
// Out-of-window accesses complete normally, drop writes, read all-ones and set bus_err.
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DEPTH_LOG2  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] BUS_addr,
    input  logic [DATA_WIDTH-1:0] BUS_wdata,
    input  logic                  BUS_mode,
    input  logic                  BUS_valid,
    output logic                  BUS_wready,
    output logic                  BUS_rvalid,
    output logic [DATA_WIDTH-1:0] BUS_rdata,
    input  logic                  BUS_rready,
    output logic                  bus_err
);

    // One bit wider than the address so a window covering the whole space still compares.
    localparam logic [ADDR_WIDTH:0] WIN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] WIN_BYTES = WIN_ONE << (DEPTH_LOG2 + 2);
    localparam logic [7:0]          WAIT_INIT = 8'(WAIT_CYCLES);

    slave_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  mode_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  win_q;
    logic                  err_q;
    logic                  rd_seen_q;
    logic                  rd_oob_q;

    logic [ADDR_WIDTH-1:0] off;
    logic                  win_now;
    logic [DEPTH_LOG2-1:0] idx_now;
    logic                  latch;
    logic                  acc_win;
    logic                  resp_entry;
    logic                  rd_entry;

    logic                  sram_we;
    logic                  sram_re;
    logic [DEPTH_LOG2-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_rdata;

    assign off     = BUS_addr - BASE_ADDR;
    assign win_now = (BUS_addr >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
    assign idx_now = off[DEPTH_LOG2+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (BUS_valid) begin
                    latch = 1'b1;
                    cnt_d = WAIT_INIT;
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                    end else begin
                        state_d = (BUS_mode == MODE_READ) ? StRresp : StWresp;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 8'd1;
                if (!BUS_valid) begin
                    state_d = StIdle;
                end else if (cnt_q == 8'd1) begin
                    state_d = (mode_q == MODE_READ) ? StRresp : StWresp;
                end
            end
            StWresp: state_d = StTurn;
            StRresp: begin
                if (BUS_rready) begin
                    state_d = StTurn;
                end else if (!BUS_valid) begin
                    state_d = StIdle;
                end
            end
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With zero wait states the response is entered straight from IDLE, before the latch.
    assign acc_win    = (state_q == StIdle) ? win_now : win_q;
    assign resp_entry = (state_d != state_q) &&
                        ((state_d == StWresp) || (state_d == StRresp));
    assign rd_entry   = (state_d == StRresp) && (state_q != StRresp);

    assign sram_addr = (state_q == StIdle) ? idx_now : idx_q;
    assign sram_re   = rd_entry;
    assign sram_we   = (state_q == StWresp) && BUS_valid && win_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            mode_q    <= MODE_READ;
            wdata_q   <= '0;
            win_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_seen_q <= 1'b0;
            rd_oob_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                idx_q   <= idx_now;
                mode_q  <= BUS_mode;
                wdata_q <= BUS_wdata;
                win_q   <= win_now;
            end
            if (resp_entry && !acc_win) begin
                err_q <= 1'b1;
            end
            if (rd_entry) begin
                rd_seen_q <= 1'b1;
                rd_oob_q  <= !acc_win;
            end
        end
    end

    sram_1rw #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk  (clk),
        .we   (sram_we),
        .re   (sram_re),
        .addr (sram_addr),
        .wdata(wdata_q),
        .rdata(sram_rdata)
    );

    // The SRAM read register is unreset; rd_seen_q masks it to zero until the first read.
    always_comb begin
        BUS_wready = (state_q == StWresp);
        BUS_rvalid = (state_q == StRresp);
        bus_err    = err_q;
        if (!rd_seen_q) begin
            BUS_rdata = '0;
        end else if (rd_oob_q) begin
            BUS_rdata = {DATA_WIDTH{OOB_RDATA_BIT}};
        end else begin
            BUS_rdata = sram_rdata;
        end
    end

endmodule

// File: doc/bus_sram_slave.md
# bus_sram_slave

Word-addressed on-chip SRAM target for the single-master CPU bus. It sits directly downstream of the bus master controller and answers its valid/ready read and write transactions. Response latency is programmable. Accesses outside the mapped window are absorbed with a defined response, so the master never hangs.

## Interface
- DATA_WIDTH, 32, bus data width in bits
- ADDR_WIDTH, 32, bus byte-address width
- DEPTH_LOG2, 10, log2 of the word count (default 1024 words)
- BASE_ADDR, 0, byte address of word 0; must be word aligned
- WAIT_CYCLES, 2, wait states before the response (0..255)

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst_n  in  1  asynchronous active-low reset
- BUS_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored
- BUS_wdata  in  DATA_WIDTH  write data
- BUS_mode  in  1  0 = read, 1 = write
- BUS_valid  in  1  request valid; held by the master until completion
- BUS_wready  out  1  write accepted; one-cycle pulse
- BUS_rvalid  out  1  read data valid; held until BUS_rready
- BUS_rdata  out  DATA_WIDTH  read data
- BUS_rready  in  1  master read acknowledge; one-cycle pulse
- bus_err  out  1  sticky flag for out-of-window access

## Operation
- Address decode:
  - off = BUS_addr − BASE_ADDR, computed at ADDR_WIDTH width.
  - The access is in window iff BUS_addr ≥ BASE_ADDR and off < 4·2^DEPTH_LOG2.
  - Word index = off[DEPTH_LOG2+1:2].
- FSM states and transitions:
  - IDLE: BUS_valid=1 latches addr, mode, wdata and the in-window bit, and loads cnt=WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, otherwise WRESP or RRESP depending on mode.
  - WAIT: cnt decrements each cycle. At cnt==1 the next state is WRESP or RRESP. BUS_valid=0 aborts to IDLE with no side effect.
  - WRESP: BUS_wready=1 for exactly one cycle. The memory write commits on that edge only if BUS_valid=1 and the access is in window. Next state is TURN.
  - RRESP: BUS_rvalid=1. BUS_rdata holds the memory word, or all-ones if out of window, and is stable until the handshake completes. BUS_rready=1 → TURN. BUS_valid=0 before BUS_rready → IDLE, and rvalid drops.
  - TURN: all handshake outputs are 0 and BUS_valid is ignored for this one cycle. Next state is IDLE. This absorbs the master's one-cycle valid tail after a completed handshake.
- Out-of-window access:
  - The handshake still completes at normal latency.
  - Writes are dropped; reads return {DATA_WIDTH{1'b1}}.
  - bus_err is set on response entry and cleared only by reset.
- Memory contents are not reset.

## Timing
- Reset values: BUS_wready=0, BUS_rvalid=0, BUS_rdata=0, bus_err=0, state=IDLE, cnt=0.
- Latency: BUS_valid sampled in IDLE at cycle T → BUS_wready or BUS_rvalid first high in cycle T+1+WAIT_CYCLES.
- The memory read is registered. BUS_rdata is valid in the same cycle BUS_rvalid rises.
- BUS_rdata keeps its last value outside RRESP.
- Back-to-back transactions: minimum spacing is 2+WAIT_CYCLES cycles per read/write plus master turnaround. The slave accepts a new request no earlier than the cycle after TURN.
- Reset asserted mid-transaction: outputs clear asynchronously and no partial write occurs. A write already committed remains in memory.
- bus_err and BUS_rvalid/BUS_wready may be high in the same cycle.

## Structure
- Shared package bus_pkg contains:
  - MODE_READ=1'b0, MODE_WRITE=1'b1 (also used by the master);
  - slave state encoding IDLE/WAIT/WRESP/RRESP/TURN;
  - the out-of-window read value constant.
- Sub-module sram_1rw (DATA_WIDTH, DEPTH_LOG2): single port, synchronous write enable, synchronous read, no reset.
- The FSM, counter, decode and flags stay in bus_sram_slave.

## Test plan
- Write/read round trip, WAIT_CYCLES=2:
  - Write 0xA5A5_0001 to 0x10 → BUS_wready pulses in cycle T+3.
  - Read 0x10 → BUS_rvalid in T+3 with BUS_rdata=0xA5A5_0001, held until BUS_rready, then low for one TURN cycle.
- WAIT_CYCLES=0: read of 0x0 after writing 0x1234 → BUS_rvalid in T+1 with 0x1234. Back-to-back reads at 0x0/0x4 both return correct data.
- Out of window, BASE_ADDR=0x1000:
  - Write 0x0 then read 0x0 → both handshakes complete; read returns 0xFFFF_FFFF; bus_err=1 and stays 1.
  - Memory word 0 is unchanged.
- Delayed acknowledge: BUS_rready asserted 5 cycles after BUS_rvalid → BUS_rvalid and BUS_rdata stay stable for all 5 cycles. Completion on the rready cycle; rvalid=0 next cycle.
- Abort and reset:
  - BUS_valid dropped during WAIT of a write to 0x8 → no BUS_wready, and memory at 0x8 is unchanged.
  - rst_n pulsed low during RRESP → BUS_rvalid=0 immediately, bus_err=0, FSM returns to IDLE.
- Master integration: bus master controller connected directly, with alternating writes and reads to 16 addresses → every rdata_valid returns the last written value and no transaction stalls.
